// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage valid/ready register chain with bubble collapse and flush; PIPE_REG_ELASTIC_STATS_EN adds stall/bubble counters.
// Latency: DEPTH cycles accept-to-out_valid_o through an empty pipe; sustains 1 entry/cycle.
// Backpressure: in_ready_o drops only when every stage is full with out_ready_i low, or while flush_i is high.
module pipe_reg_elastic #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    output logic [WIDTH-1:0]             out_data_o,
    input  logic                         out_ready_i,
    input  logic                         flush_i,
`ifdef PIPE_REG_ELASTIC_STATS_EN
    output logic [31:0]                  stall_cnt_o,
    output logic [31:0]                  bubble_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_dat [DEPTH];
    logic [CW-1:0]    r_cnt;

    logic [DEPTH-1:0] w_adv;
    logic             w_acc;
    logic             w_emit;

    // A stage advances when it is valid and some stage downstream of it is
    // empty or the output is being taken; scanning from the output end keeps
    // the ripple as a running OR instead of a self-referencing vector.
    always_comb begin
        logic w_free;
        w_adv  = '0;
        w_free = out_ready_i;
        for (int k = DEPTH-1; k >= 0; k--) begin
            w_adv[k] = r_vld[k] & w_free;
            w_free   = w_free | ~r_vld[k];
        end
    end

    assign in_ready_o  = (~r_vld[0] | w_adv[0]) & ~flush_i;
    assign w_acc       = in_valid_i & in_ready_o;
    assign w_emit      = r_vld[DEPTH-1] & out_ready_i;
    assign out_valid_o = r_vld[DEPTH-1];
    assign out_data_o  = r_dat[DEPTH-1];
    assign count_o     = r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_dat[k] <= RESET_VAL;
            end
        end else begin
            if (w_acc) begin
                r_vld[0] <= 1'b1;
                r_dat[0] <= in_data_i;
            end else if (w_adv[0]) begin
                r_vld[0] <= 1'b0;
            end
            // Data only moves on a load, so a stalled last stage never changes.
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k-1]) begin
                    r_vld[k] <= 1'b1;
                    r_dat[k] <= r_dat[k-1];
                end else if (w_adv[k]) begin
                    r_vld[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_acc, w_emit})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef PIPE_REG_ELASTIC_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Counters survive flush so stall history spans mispredicts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_vld[DEPTH-1] && !out_ready_i && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!r_vld[DEPTH-1] && out_ready_i && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: directed vector table, stats sequence, then random traffic against an entry-position model.
module tb_pipe_reg_elastic;

    localparam int          W  = 32;
    localparam int          D  = 2;
    localparam logic [W-1:0] RV = '0;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, in_valid_i, out_ready_i;
    logic [W-1:0]  in_data_i;
    logic          in_ready_o, out_valid_o;
    logic [W-1:0]  out_data_o;
    logic [$clog2(D+1)-1:0] count_o;
`ifdef PIPE_REG_ELASTIC_STATS_EN
    logic [31:0]   stall_cnt_o, bubble_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_reg_elastic #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .flush_i     (flush_i),
`ifdef PIPE_REG_ELASTIC_STATS_EN
        .stall_cnt_o (stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o),
`endif
        .count_o     (count_o)
    );

    typedef struct {
        logic          rst, flush, iv, ordy;
        logic [W-1:0]  id;
        logic          chk, chk_dat;
        logic          e_ir, e_ov;
        logic [W-1:0]  e_od;
        int            e_cnt;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } ent_t;

    vec_t tv[$];
    ent_t mq[$];
    bit   m_rv;
    int   m_stall, m_bub;

    function automatic vec_t mk(input logic rst, flush, iv, input logic [W-1:0] id, input logic ordy,
                                input logic chk, chk_dat, e_ir, e_ov, input logic [W-1:0] e_od, input int e_cnt);
        vec_t v;
        v.rst = rst; v.flush = flush; v.iv = iv; v.id = id; v.ordy = ordy;
        v.chk = chk; v.chk_dat = chk_dat; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, flush, iv, input logic [W-1:0] id, input logic ordy);
        rst_i = rst; flush_i = flush; in_valid_i = iv; in_data_i = id; out_ready_i = ordy;
    endtask

    task automatic cyc(input logic rst, flush, iv, input logic [W-1:0] id, input logic ordy);
        drive(rst, flush, iv, id, ordy);
        @(posedge clk);
        #1;
    endtask

    // Entry-level model: entries oldest-first with a stage position; each
    // cycle every entry climbs one stage unless the entry ahead blocks it.
    task automatic model_step(input logic rst, flush, iv, input logic [W-1:0] id, input logic ordy);
        bit ov, ir, acc;
        int lim, np;
        ov  = (mq.size() > 0) && (mq[0].pos == D-1);
        ir  = !flush && ((mq.size() < D) || ordy);
        acc = iv && ir;
        if (rst) begin
            m_stall = 0;
            m_bub   = 0;
        end else begin
            if (ov && !ordy) m_stall++;
            if (!ov && ordy) m_bub++;
        end
        if (rst || flush) begin
            mq.delete();
            m_rv = 1'b1;
            return;
        end
        if (ov && ordy) void'(mq.pop_front());
        lim = D-1;
        for (int j = 0; j < mq.size(); j++) begin
            np = (mq[j].pos + 1 < lim) ? mq[j].pos + 1 : lim;
            if (np != mq[j].pos && np == D-1) m_rv = 1'b0;
            mq[j].pos = np;
            lim = np - 1;
        end
        if (acc) begin
            ent_t e;
            e.d = id;
            e.pos = 0;
            mq.push_back(e);
            if (D == 1) m_rv = 1'b0;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // rst flush iv data ordy | chk chk_dat ir ov od cnt
        tv.push_back(mk(1,0,0,32'h0 ,1, 0,0,0,0,32'h0 ,0));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,0,32'h0 ,0));   // reset state
        tv.push_back(mk(0,0,1,32'h11,1, 1,0,1,0,32'h0 ,0));   // streaming
        tv.push_back(mk(0,0,1,32'h22,1, 1,0,1,0,32'h0 ,1));
        tv.push_back(mk(0,0,1,32'h33,1, 1,1,1,1,32'h11,2));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,1,32'h22,2));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,1,32'h33,1));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,0,1,0,32'h0 ,0));
        tv.push_back(mk(0,0,1,32'hA1,0, 1,0,1,0,32'h0 ,0));   // stall + bubble collapse
        tv.push_back(mk(0,0,0,32'h0 ,0, 1,0,1,0,32'h0 ,1));
        tv.push_back(mk(0,0,1,32'hB2,0, 1,1,1,1,32'hA1,1));
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(0,0,0,32'h0 ,0, 1,1,0,1,32'hA1,2));
        tv.push_back(mk(0,0,1,32'hC3,1, 1,1,1,1,32'hA1,2));   // full: emit + accept
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,1,32'hB2,2));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,1,32'hC3,1));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,0,1,0,32'h0 ,0));
        tv.push_back(mk(0,0,1,32'h55,0, 1,0,1,0,32'h0 ,0));   // flush
        tv.push_back(mk(0,0,1,32'h66,0, 1,0,1,0,32'h0 ,1));
        tv.push_back(mk(0,1,1,32'h77,0, 1,1,0,1,32'h55,2));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,0,32'h0 ,0));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,0,32'h0 ,0));
        tv.push_back(mk(0,0,1,32'h88,0, 1,0,1,0,32'h0 ,0));   // reset beats flush
        tv.push_back(mk(1,1,1,32'h99,0, 1,0,0,0,32'h0 ,1));
        tv.push_back(mk(0,0,0,32'h0 ,1, 1,1,1,0,32'h0 ,0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].flush, tv[i].iv, tv[i].id, tv[i].ordy);
            @(negedge clk);
            if (tv[i].chk) begin
                check($sformatf("vec%0d in_ready", i), 32'(in_ready_o), 32'(tv[i].e_ir));
                check($sformatf("vec%0d out_valid", i), 32'(out_valid_o), 32'(tv[i].e_ov));
                check($sformatf("vec%0d count", i), 32'(count_o), 32'(tv[i].e_cnt));
                if (tv[i].chk_dat)
                    check($sformatf("vec%0d out_data", i), out_data_o, tv[i].e_od);
            end
            @(posedge clk);
            #1;
        end

`ifdef PIPE_REG_ELASTIC_STATS_EN
        cyc(1,0,0,32'h0,0);
        cyc(0,0,1,32'hE1,0);
        cyc(0,0,0,32'h0,0);
        for (int i = 0; i < 3; i++) cyc(0,0,0,32'h0,0);
        cyc(0,0,0,32'h0,1);
        for (int i = 0; i < 4; i++) cyc(0,0,0,32'h0,1);
        check("stats stall_cnt", stall_cnt_o, 32'd3);
        check("stats bubble_cnt", bubble_cnt_o, 32'd4);
        cyc(0,1,0,32'h0,0);
        check("stats stall after flush", stall_cnt_o, 32'd3);
        check("stats bubble after flush", bubble_cnt_o, 32'd4);
`endif

        mq.delete();
        m_rv = 1'b1;
        m_stall = 0;
        m_bub = 0;
        for (int i = 0; i < 4000; i++) begin
            logic r, f, v, o;
            logic [W-1:0] d;
            int bias;
            bit e_ov, e_ir;
            bias = ((i / 250) % 2 == 1) ? 25 : 85;
            r = (i == 0) || ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 99) < 70);
            o = ($urandom_range(0, 99) < bias);
            d = $urandom;
            drive(r, f, v, d, o);
            @(negedge clk);
            e_ov = (mq.size() > 0) && (mq[0].pos == D-1);
            e_ir = !f && ((mq.size() < D) || o);
            if (i > 0) begin
                check("rand in_ready", 32'(in_ready_o), 32'(e_ir));
                check("rand out_valid", 32'(out_valid_o), 32'(e_ov));
                check("rand count", 32'(count_o), 32'(mq.size()));
                if (e_ov)
                    check("rand out_data", out_data_o, mq[0].d);
                else if (m_rv)
                    check("rand out_data reset value", out_data_o, RV);
`ifdef PIPE_REG_ELASTIC_STATS_EN
                check("rand stall_cnt", stall_cnt_o, 32'(m_stall));
                check("rand bubble_cnt", bubble_cnt_o, 32'(m_bub));
`endif
            end
            model_step(r, f, v, d, o);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
